mem_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-port memory (SIZE = 8 entries, 8-bit data, 3-bit address from mem_design_pkg) between NUM_REQ requesters. It sits between requester front-ends (APB slave, sort engine, search engine) and the memory core. It grants one request at a time, latches its command and drives the memory-side request/acknowledge handshake. It then returns the read data and a one-cycle completion pulse to the winning requester.

---
 rtl/mem_design_pkg.sv | 13 +
 rtl/mem_req_arbiter_if.sv | 36 +++
 rtl/mem_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_design_pkg.sv
// Shared memory-subsystem constants: geometry of the 8-entry single-port memory
// and the encoding of a memory operation.
package mem_design_pkg;

    localparam int param_WIDTH_DATA = 8;
    localparam int param_WIDTH_ADDR = 3;

    typedef enum logic {
        mem_read  = 1'b0,
        mem_write = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_req_arbiter.
// master = the arbiter, slave = the requesters/memory environment.
interface mem_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_DATA = mem_design_pkg::param_WIDTH_DATA,
    parameter int WIDTH_ADDR = mem_design_pkg::param_WIDTH_ADDR
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_op;
    logic [NUM_REQ*WIDTH_ADDR-1:0] req_addr;
    logic [NUM_REQ*WIDTH_DATA-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_done;
    logic [WIDTH_DATA-1:0]         req_rdata;
    logic                          req_err;

    logic                          mem_req;
    logic                          mem_op;
    logic [WIDTH_ADDR-1:0]         mem_addr;
    logic [WIDTH_DATA-1:0]         mem_wdata;
    logic                          mem_ack;
    logic [WIDTH_DATA-1:0]         mem_rdata;

    logic                          busy;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_done, req_rdata, req_err, mem_req, mem_op, mem_addr, mem_wdata, busy
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_done, req_rdata, req_err, mem_req, mem_op, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory among NUM_REQ requesters.
// Optional mem_ack watchdog is built only when ARB_TIMEOUT_EN is defined.
module mem_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH_DATA  = mem_design_pkg::param_WIDTH_DATA,
    parameter int WIDTH_ADDR  = mem_design_pkg::param_WIDTH_ADDR,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_req_arbiter_if.master  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CW    = IDX_W + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mem_req_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    arb_state_t             state_q;
    arb_state_t             state_d;

    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       grant_q;
    logic                   op_q;
    logic [WIDTH_ADDR-1:0]  addr_q;
    logic [WIDTH_DATA-1:0]  wdata_q;
    logic                   mem_req_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [WIDTH_DATA-1:0]  rdata_q;
    logic                   err_q;

    logic                   any_req;
    logic [IDX_W-1:0]       pick_idx;
    logic [CW-1:0]          cand;
    logic                   timeout_hit;

    // First pending request at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        any_req  = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!any_req && bus.req_valid[cand[IDX_W-1:0]]) begin
                any_req  = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == ARB_ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == ARB_WAIT && !bus.mem_ack) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Hit on the last allowed cycle so exactly TIMEOUT_CYC cycles are spent in ARB_WAIT.
    assign timeout_hit = (state_q == ARB_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (any_req) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (bus.mem_ack || timeout_hit) state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            grant_q   <= '0;
            op_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_req_q <= 1'b0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_q <= pick_idx;
                        op_q    <= bus.req_op[pick_idx];
                        addr_q  <= bus.req_addr[pick_idx*WIDTH_ADDR +: WIDTH_ADDR];
                        wdata_q <= bus.req_wdata[pick_idx*WIDTH_DATA +: WIDTH_DATA];
                    end
                end
                ARB_ISSUE: begin
                    mem_req_q <= 1'b1;
                end
                ARB_WAIT: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        rdata_q   <= (op_q == mem_design_pkg::mem_write) ? '0 : bus.mem_rdata;
                        err_q     <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    done_q <= NUM_REQ'(1) << grant_q;
                    ptr_q  <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_op    = op_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.req_done  = done_q;
    assign bus.req_rdata = rdata_q;
    assign bus.req_err   = err_q;
    assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: directed requester stimulus, a memory
// responder model, and a negedge monitor that checks every mem_req and req_done.
module tb_mem_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WD      = 8;
    localparam int WA      = 3;
    localparam int TO      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_req_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH_DATA(WD), .WIDTH_ADDR(WA)) bus ();

    mem_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .WIDTH_DATA (WD),
        .WIDTH_ADDR (WA),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] done;
        logic [7:0] rdata;
        logic       err;
    } done_exp_t;

    typedef struct {
        logic       op;
        logic [2:0] addr;
        logic [7:0] wdata;
    } mem_exp_t;

    done_exp_t  done_q[$];
    mem_exp_t   mem_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] tbl [8];
    bit         ack_en    = 1'b1;
    int         ack_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic op, input logic [2:0] a, input logic [7:0] wd);
        mem_q.push_back('{op: op, addr: a, wdata: wd});
    endtask

    task automatic exp_done(input logic [3:0] d, input logic [7:0] rd, input logic e);
        done_q.push_back('{done: d, rdata: rd, err: e});
    endtask

    task automatic set_req(input int i, input logic op, input logic [2:0] a, input logic [7:0] wd);
        bus.req_op[i]          = op;
        bus.req_addr[i*WA +: WA] = a;
        bus.req_wdata[i*WD +: WD] = wd;
        bus.req_valid[i]       = 1'b1;
    endtask

    // Requester side: wait for its completion pulse, then withdraw within that cycle.
    task automatic wait_done(input int idx, input int budget);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.req_done[idx] === 1'b1) begin
                bus.req_valid[idx] = 1'b0;
                break;
            end
            k++;
            if (k >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_done_%0d: no req_done within %0d cycles, required one", idx, budget);
                bus.req_valid[idx] = 1'b0;
                break;
            end
        end
    endtask

    // Memory model: acknowledges ack_delay cycles after seeing mem_req, data from tbl.
    int wcnt  = 0;
    bit acked = 1'b0;
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req !== 1'b1) begin
                acked = 1'b0;
                wcnt  = 0;
            end else if (ack_en && !acked) begin
                if (wcnt >= ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = tbl[bus.mem_addr];
                    acked         = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    logic     mem_req_d = 1'b0;
    mem_exp_t cur_mem;
    always @(negedge clk) begin
        done_exp_t de;
        if (bus.req_done !== 4'b0000) begin
            if (done_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got %b, required none", bus.req_done);
            end else begin
                de = done_q.pop_front();
                chk("done_onehot", 32'(bus.req_done), 32'(de.done));
                chk("done_rdata", 32'(bus.req_rdata), 32'(de.rdata));
                chk("done_err", 32'(bus.req_err), 32'(de.err));
            end
        end
        if (bus.mem_req === 1'b1 && mem_req_d !== 1'b1) begin
            if (mem_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mem_req: got addr %0d, required no request", bus.mem_addr);
            end else begin
                cur_mem = mem_q.pop_front();
                chk("mem_op", 32'(bus.mem_op), 32'(cur_mem.op));
                chk("mem_addr", 32'(bus.mem_addr), 32'(cur_mem.addr));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur_mem.wdata));
            end
        end else if (bus.mem_req === 1'b1) begin
            chk("mem_fields_stable", 32'({bus.mem_op, bus.mem_addr, bus.mem_wdata}),
                32'({cur_mem.op, cur_mem.addr, cur_mem.wdata}));
        end
        mem_req_d = bus.mem_req;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int seen;
    int k;
    int cnt;

    initial begin
        tbl = '{8'h0F, 8'h21, 8'h32, 8'hFF, 8'h54, 8'hA7, 8'h5E, 8'h70};
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_req_done", 32'(bus.req_done), 0);
        chk("rst_req_err", 32'(bus.req_err), 0);
        chk("rst_req_rdata", 32'(bus.req_rdata), 0);
        chk("rst_mem_fields", 32'({bus.mem_op, bus.mem_addr, bus.mem_wdata}), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single read by requester 2, exact cycle timing.
        @(posedge clk); #1;
        set_req(2, 1'b0, 3'd5, 8'h00);
        exp_mem(1'b0, 3'd5, 8'h00);
        exp_done(4'b0100, 8'hA7, 1'b0);
        @(posedge clk); #1;
        chk("rd_issue_mem_req", 32'(bus.mem_req), 0);
        chk("rd_issue_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
        chk("rd_mem_req_up", 32'(bus.mem_req), 1);
        chk("rd_mem_addr", 32'(bus.mem_addr), 5);
        @(posedge clk); #1;
        chk("rd_mem_req_down", 32'(bus.mem_req), 0);
        chk("rd_done_not_yet", 32'(bus.req_done), 0);
        @(posedge clk); #1;
        chk("rd_done_pulse", 32'(bus.req_done), 32'h4);
        chk("rd_rdata", 32'(bus.req_rdata), 32'hA7);
        bus.req_valid[2] = 1'b0;
        @(posedge clk); #1;
        chk("rd_done_one_cycle", 32'(bus.req_done), 0);

        // Pointer at 3: requester 3 withdraws before the decision, so 0 wins.
        set_req(0, 1'b0, 3'd6, 8'h00);
        set_req(3, 1'b0, 3'd1, 8'h00);
        exp_mem(1'b0, 3'd6, 8'h00);
        exp_done(4'b0001, 8'h5E, 1'b0);
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        wait_done(0, 20);

        // Write with a slow memory; write completions return zero data.
        @(posedge clk); #1;
        ack_delay = 5;
        set_req(0, 1'b1, 3'd3, 8'h3C);
        exp_mem(1'b1, 3'd3, 8'h3C);
        exp_done(4'b0001, 8'h00, 1'b0);
        wait_done(0, 40);
        ack_delay = 0;

        // Reset while waiting for mem_ack: transaction dropped, no completion.
        @(posedge clk); #1;
        ack_en = 1'b0;
        set_req(3, 1'b0, 3'd2, 8'h00);
        exp_mem(1'b0, 3'd2, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_mem_req", 32'(bus.mem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(bus.mem_req), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_done", 32'(bus.req_done), 0);
        bus.req_valid[3] = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(bus.busy), 0);

        set_req(1, 1'b0, 3'd7, 8'h00);
        exp_mem(1'b0, 3'd7, 8'h00);
        exp_done(4'b0010, 8'h70, 1'b0);
        wait_done(1, 20);

        @(posedge clk); #1;
        set_req(3, 1'b1, 3'd4, 8'h99);
        exp_mem(1'b1, 3'd4, 8'h99);
        exp_done(4'b1000, 8'h00, 1'b0);
        wait_done(3, 20);

        // Fairness: pointer is 0, all four held high across eight grants.
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                exp_mem(1'b0, 3'(i), 8'(8'h80 + i));
                exp_done(4'b0001 << i, tbl[i], 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 3'(i), 8'(8'h80 + i));
        end
        seen = 0;
        k    = 0;
        while (seen < 8 && k < 200) begin
            @(negedge clk);
            k++;
            if (bus.req_done !== 4'b0000) begin
                seen++;
                if (seen == 8) bus.req_valid = '0;
            end
        end
        bus.req_valid = '0;
        chk("fair_completions", 32'(seen), 8);

        // Memory never acknowledges.
        @(posedge clk); #1;
        ack_en = 1'b0;
        set_req(2, 1'b0, 3'd5, 8'h00);
        exp_mem(1'b0, 3'd5, 8'h00);
`ifdef ARB_TIMEOUT_EN
        exp_done(4'b0100, 8'h00, 1'b1);
        cnt = 0;
        k   = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (bus.mem_req === 1'b1) cnt++;
            if (bus.req_done[2] === 1'b1) begin
                bus.req_valid[2] = 1'b0;
                break;
            end
        end
        chk("timeout_wait_cycles", 32'(cnt), 32'(TO));
`else
        repeat (40) @(negedge clk);
        chk("no_timeout_mem_req", 32'(bus.mem_req), 1);
        chk("no_timeout_busy", 32'(bus.busy), 1);
        bus.req_valid[2] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
`endif
        ack_en = 1'b1;

        repeat (5) @(negedge clk);
        chk("done_queue_drained", 32'(done_q.size()), 0);
        chk("mem_queue_drained", 32'(mem_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
